// File: rtl/sat_pkg.sv
// Shared definitions for the SAT engine variable side.
// Holds the variable value codes, the var_state FSM encoding, the lit-cell
// bus payload and the default widths.
package sat_pkg;

  localparam int unsigned LEVEL_W_DEF  = 8;
  localparam int unsigned CLAUSE_W_DEF = 8;
  localparam int unsigned VAL_W        = 2;

  typedef logic [VAL_W-1:0] val_t;

  localparam val_t VAL_FREE     = 2'd0;
  localparam val_t VAL_FALSE    = 2'd1;
  localparam val_t VAL_TRUE     = 2'd2;
  localparam val_t VAL_CONFLICT = 2'd3;

  typedef enum logic [1:0] {
    S_FREE     = 2'd0,
    S_DECIDED  = 2'd1,
    S_IMPLIED  = 2'd2,
    S_CONFLICT = 2'd3
  } state_e;

  // Lit-cell bus word: {val, flag}. Towards the lit cells flag means
  // "value was implied"; from the lit cells flag means "implication valid".
  typedef struct packed {
    val_t val;
    logic flag;
  } lit_bus_t;

  // True for a concrete polarity (FALSE or TRUE).
  function automatic logic is_polarity(val_t v);
    return (v == VAL_FALSE) || (v == VAL_TRUE);
  endfunction

endpackage

// File: rtl/var_state_if.sv
// Solver / lit-cell facing bundle of one var_state cell.
// master : solver side (drives decisions, backtracks, implication bus)
// slave  : var_state itself
// Optional macro VAR_STATE_REASON_EN adds reason_i / reason_o.
interface var_state_if
  import sat_pkg::*;
#(
  parameter int unsigned LEVEL_W = LEVEL_W_DEF
`ifdef VAR_STATE_REASON_EN
  , parameter int unsigned CLAUSE_W = CLAUSE_W_DEF
`endif
);

  logic               decide_i;
  val_t               decide_val_i;
  logic [LEVEL_W-1:0] cur_level_i;
  lit_bus_t           var_value_i;
  logic               backtrack_i;
  logic [LEVEL_W-1:0] bt_level_i;

  logic               wr_o;
  lit_bus_t           var_value_o;
  logic [LEVEL_W-1:0] level_o;
  logic               ack_o;
  logic               conflict_o;

`ifdef VAR_STATE_REASON_EN
  logic [CLAUSE_W-1:0] reason_i;
  logic [CLAUSE_W-1:0] reason_o;

  modport master (
    output decide_i, decide_val_i, cur_level_i, var_value_i,
           backtrack_i, bt_level_i, reason_i,
    input  wr_o, var_value_o, level_o, ack_o, conflict_o, reason_o
  );

  modport slave (
    input  decide_i, decide_val_i, cur_level_i, var_value_i,
           backtrack_i, bt_level_i, reason_i,
    output wr_o, var_value_o, level_o, ack_o, conflict_o, reason_o
  );
`else
  modport master (
    output decide_i, decide_val_i, cur_level_i, var_value_i,
           backtrack_i, bt_level_i,
    input  wr_o, var_value_o, level_o, ack_o, conflict_o
  );

  modport slave (
    input  decide_i, decide_val_i, cur_level_i, var_value_i,
           backtrack_i, bt_level_i,
    output wr_o, var_value_o, level_o, ack_o, conflict_o
  );
`endif

endinterface

// File: rtl/var_state.sv
// Per-variable state cell of the SAT engine.
// Owns one variable's value, the decision level it was set at and whether it
// was decided or implied; flags conflicting implications and frees the
// variable on backtrack. Event priority: backtrack > implication > decision.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : var_state_if.slave (decide/backtrack/implication in,
//          wr/var_value/level/ack/conflict out, all outputs registered)
// Optional macro VAR_STATE_REASON_EN: latches the implying clause index.
module var_state
  import sat_pkg::*;
#(
  parameter int unsigned LEVEL_W = LEVEL_W_DEF
`ifdef VAR_STATE_REASON_EN
  , parameter int unsigned CLAUSE_W = CLAUSE_W_DEF
`endif
) (
  input logic        clk,
  input logic        rst,
  var_state_if.slave bus
);

  state_e             state_q, state_d;
  val_t               val_q, val_d;
  logic               imp_q, imp_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               wr_q, wr_d;
  logic               ack_q, ack_d;
  logic               conflict_q;
  logic               imp_vld;
  logic               bt_hit;
`ifdef VAR_STATE_REASON_EN
  logic [CLAUSE_W-1:0] reason_q, reason_d;
`endif

  // A valid implication carrying value 0 is treated as no implication.
  assign imp_vld = bus.var_value_i.flag && (bus.var_value_i.val != VAL_FREE);

  // Backtrack only takes effect when it actually undoes this variable.
  assign bt_hit = bus.backtrack_i &&
                  ((state_q == S_CONFLICT) ||
                   (((state_q == S_DECIDED) || (state_q == S_IMPLIED)) &&
                    (level_q > bus.bt_level_i)));

  // Next state and next output values.
  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    imp_d    = imp_q;
    level_d  = level_q;
    wr_d     = 1'b0;
    ack_d    = 1'b0;
`ifdef VAR_STATE_REASON_EN
    reason_d = reason_q;
`endif

    if (bt_hit) begin
      state_d  = S_FREE;
      val_d    = VAL_FREE;
      imp_d    = 1'b0;
      level_d  = '0;
      wr_d     = 1'b1;
`ifdef VAR_STATE_REASON_EN
      reason_d = '0;
`endif
    end else if (imp_vld && (state_q != S_CONFLICT)) begin
      // Same value on an assigned variable is a no-op; anything else moves.
      if ((state_q == S_FREE) || (bus.var_value_i.val != val_q)) begin
        if ((state_q == S_FREE) && is_polarity(bus.var_value_i.val)) begin
          state_d = S_IMPLIED;
          val_d   = bus.var_value_i.val;
        end else begin
          // Opposite polarity, or both polarities OR-merged on the bus.
          state_d = S_CONFLICT;
          val_d   = VAL_CONFLICT;
        end
        imp_d    = 1'b1;
        level_d  = bus.cur_level_i;
        wr_d     = 1'b1;
`ifdef VAR_STATE_REASON_EN
        reason_d = bus.reason_i;
`endif
      end
    end else if (bus.decide_i && (state_q == S_FREE) &&
                 is_polarity(bus.decide_val_i)) begin
      state_d  = S_DECIDED;
      val_d    = bus.decide_val_i;
      imp_d    = 1'b0;
      level_d  = bus.cur_level_i;
      wr_d     = 1'b1;
      ack_d    = 1'b1;
`ifdef VAR_STATE_REASON_EN
      reason_d = '0;
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FREE;
      val_q      <= VAL_FREE;
      imp_q      <= 1'b0;
      level_q    <= '0;
      wr_q       <= 1'b0;
      ack_q      <= 1'b0;
      conflict_q <= 1'b0;
`ifdef VAR_STATE_REASON_EN
      reason_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      imp_q      <= imp_d;
      level_q    <= level_d;
      wr_q       <= wr_d;
      ack_q      <= ack_d;
      conflict_q <= (state_d == S_CONFLICT);
`ifdef VAR_STATE_REASON_EN
      reason_q   <= reason_d;
`endif
    end
  end

  assign bus.wr_o        = wr_q;
  assign bus.var_value_o = lit_bus_t'({val_q, imp_q});
  assign bus.level_o     = level_q;
  assign bus.ack_o       = ack_q;
  assign bus.conflict_o  = conflict_q;
`ifdef VAR_STATE_REASON_EN
  assign bus.reason_o    = reason_q;
`endif

endmodule
